// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, instruction-memory request handshake and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the PerfFetched / PerfStallCycles counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PC_WriteEnable,
  input  logic        IFIDWriteEnable,
  input  logic        IFIDFlush,
  input  logic        Branch,
  input  logic [31:0] BranchDest,
  input  logic        Jump,
  input  logic [31:0] JumpDest,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PC,
  output logic        ID_Valid,
  output logic        FetchStall
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] PerfFetched,
  output logic [31:0] PerfStallCycles
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_addr, r_buf, r_id_instr, r_id_pc;
  logic        r_req, r_id_valid;
  logic        w_redir, w_ack, w_accept;
  logic [31:0] w_target, w_pc_nxt, w_word;

  assign w_redir  = Branch | Jump;
  assign w_target = {Branch ? BranchDest[31:2] : JumpDest[31:2], 2'b00};
  assign w_ack    = r_req & IMemAck;
  assign w_word   = (r_state == HOLD) ? r_buf : IMemRData;
  assign w_accept = ((r_state == FETCH && w_ack) || r_state == HOLD) && IFIDWriteEnable
                    && PC_WriteEnable && !w_redir;
  assign w_pc_nxt = w_redir ? w_target : w_accept ? r_pc + 32'd4 : r_pc;

  // A redirect without an ack must still wait out the old request in DISCARD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = FETCH;
      FETCH:   w_state_nxt = (w_redir && !w_ack) ? DISCARD :
                             (w_ack && !w_redir && !w_accept) ? HOLD : FETCH;
      HOLD:    w_state_nxt = (w_redir || w_accept) ? FETCH : HOLD;
      DISCARD: w_state_nxt = w_ack ? FETCH : DISCARD;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_buf      <= NOP_INSTR;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= 32'h0;
      r_id_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= (w_state_nxt == FETCH) || (w_state_nxt == DISCARD);
      if (w_state_nxt == FETCH) r_addr <= w_pc_nxt;
      if (r_state == FETCH && w_state_nxt == HOLD) r_buf <= IMemRData;
      else if (w_state_nxt != HOLD) r_buf <= NOP_INSTR;
      if (IFIDFlush) begin
        r_id_instr <= NOP_INSTR;
        r_id_valid <= 1'b0;
      end else if (IFIDWriteEnable) begin
        r_id_instr <= w_accept ? w_word : NOP_INSTR;
        r_id_pc    <= r_pc;
        r_id_valid <= w_accept;
      end
    end

  assign IMemReq        = r_req;
  assign IMemAddr       = r_addr;
  assign ID_Instruction = r_id_instr;
  assign ID_PC          = r_id_pc;
  assign ID_Valid       = r_id_valid;
  assign FetchStall     = (r_state == FETCH || r_state == DISCARD) && r_req && !IMemAck;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_stall;

  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      r_perf_fetched <= 32'h0;
      r_perf_stall   <= 32'h0;
    end else begin
      if (w_accept && r_perf_fetched != 32'hFFFF_FFFF) r_perf_fetched <= r_perf_fetched + 32'd1;
      if ((FetchStall || r_state == HOLD) && r_perf_stall != 32'hFFFF_FFFF)
        r_perf_stall <= r_perf_stall + 32'd1;
    end

  assign PerfFetched     = r_perf_fetched;
  assign PerfStallCycles = r_perf_stall;
`endif
endmodule
